// File: rtl/ocsim_axim_tester.sv
// Simulation AXI4 traffic tester: writes patterned bursts, reads them back, counts mismatches.
// Optional macro OCSIM_AXIM_TESTER_RANDOM_READY_EN randomises rready/bready.

package oclib_pkg;
    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
    } axi4m_a_s;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  strb;
        logic         last;
    } axi4m_256_w_s;

    typedef struct packed {
        logic [5:0]   id;
        logic [255:0] data;
        logic [1:0]   resp;
        logic         last;
    } axi4m_256_r_s;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } axi4m_b_s;

    typedef struct packed {
        axi4m_a_s     aw;
        logic         awvalid;
        axi4m_a_s     ar;
        logic         arvalid;
        axi4m_256_w_s w;
        logic         wvalid;
        logic         rready;
        logic         bready;
    } axi4m_256_s;

    typedef struct packed {
        logic         awready;
        logic         arready;
        logic         wready;
        axi4m_256_r_s r;
        logic         rvalid;
        axi4m_b_s     b;
        logic         bvalid;
    } axi4m_256_fb_s;
endpackage

`ifdef OCSIM_AXIM_TESTER_RANDOM_READY_EN
package ocsim_pkg;
    function automatic bit RandPercent(input int percent);
        return int'($urandom_range(99, 0)) < percent;
    endfunction
endpackage
`endif

module ocsim_axim_tester #(
    parameter type         AximType        = oclib_pkg::axi4m_256_s,
    parameter type         AximFbType      = oclib_pkg::axi4m_256_fb_s,
    parameter logic [31:0] BaseAddress     = 32'h0000_0000,
    parameter int          Bursts          = 16,
    parameter int          BurstLen        = 4,
    parameter int          AxiId           = 0,
    parameter int          ErrorCountWidth = 16
) (
    input  logic                       clockAxim,
    input  logic                       resetAxim,
    output AximType                    axim,
    input  AximFbType                  aximFb,
    input  logic                       go,
    input  logic [31:0]                seed,
    output logic                       busy,
    output logic                       done,
    output logic [ErrorCountWidth-1:0] errors
);

    localparam int DataW      = $bits(axim.w.data);
    localparam int StrbW      = $bits(axim.w.strb);
    localparam int IdW        = $bits(axim.aw.id);
    localparam int Bytes      = DataW / 8;
    localparam int Lanes      = DataW / 32;
    localparam int BurstBytes = BurstLen * Bytes;

    localparam logic [31:0] LastBurst = 32'(Bursts - 1);
    localparam logic [8:0]  LastBeat  = 9'(BurstLen - 1);
    localparam logic [7:0]  LenVal    = 8'(BurstLen - 1);
    localparam logic [2:0]  SizeVal   = 3'($clog2(Bytes));
    localparam logic [IdW-1:0] IdVal  = IdW'(AxiId);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [31:0]                seed_q, seed_d;
    logic [31:0]                burst_q, burst_d;
    logic [8:0]                 beat_q, beat_d;
    logic [ErrorCountWidth-1:0] errors_q, errors_d;

    logic [31:0]                burst_addr;
    logic [31:0]                beat_addr;
    logic [DataW-1:0]           exp_data;
    logic [2:0]                 err_inc;
    logic [ErrorCountWidth+2:0] err_sum;
    logic                       ready_en;

    function automatic logic [DataW-1:0] pattern(input logic [31:0] addr, input logic [31:0] s);
        logic [DataW-1:0] d;
        d = '0;
        for (int j = 0; j < Lanes; j++) begin
            d[j*32 +: 32] = (addr + 32'(4 * j)) ^ s;
        end
        return d;
    endfunction

`ifdef OCSIM_AXIM_TESTER_RANDOM_READY_EN
    int   ReadyPercent = 50;
    logic rand_ready_q;

    always_ff @(posedge clockAxim or negedge resetAxim) begin
        if (!resetAxim) rand_ready_q <= 1'b0;
        else            rand_ready_q <= ocsim_pkg::RandPercent(ReadyPercent);
    end

    assign ready_en = rand_ready_q;
`else
    assign ready_en = 1'b1;
`endif

    assign burst_addr = BaseAddress + burst_q * 32'(BurstBytes);
    assign beat_addr  = burst_addr + 32'(beat_q) * 32'(Bytes);
    assign exp_data   = pattern(beat_addr, seed_q);

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        errors_d = errors_q;
        err_inc  = 3'd0;
        axim     = '0;

        unique case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d  = WR_ADDR;
                    seed_d   = seed;
                    burst_d  = '0;
                    beat_d   = '0;
                    errors_d = '0;
                end
            end
            WR_ADDR: begin
                axim.awvalid  = 1'b1;
                axim.aw.id    = IdVal;
                axim.aw.addr  = burst_addr;
                axim.aw.len   = LenVal;
                axim.aw.size  = SizeVal;
                axim.aw.burst = 2'b01;
                if (aximFb.awready) state_d = WR_DATA;
            end
            WR_DATA: begin
                axim.wvalid = 1'b1;
                axim.w.data = exp_data;
                axim.w.strb = {StrbW{1'b1}};
                axim.w.last = (beat_q == LastBeat);
                if (aximFb.wready) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = WR_RESP;
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            WR_RESP: begin
                axim.bready = ready_en;
                if (aximFb.bvalid && ready_en) begin
                    err_inc = 3'(aximFb.b.resp != 2'b00) + 3'(aximFb.b.id != IdVal);
                    if (burst_q == LastBurst) begin
                        burst_d = '0;
                        state_d = RD_ADDR;
                    end else begin
                        burst_d = burst_q + 32'd1;
                        state_d = WR_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                axim.arvalid  = 1'b1;
                axim.ar.id    = IdVal;
                axim.ar.addr  = burst_addr;
                axim.ar.len   = LenVal;
                axim.ar.size  = SizeVal;
                axim.ar.burst = 2'b01;
                if (aximFb.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                axim.rready = ready_en;
                if (aximFb.rvalid && ready_en) begin
                    err_inc = 3'(aximFb.r.data != exp_data) + 3'(aximFb.r.resp != 2'b00)
                            + 3'(aximFb.r.id != IdVal)
                            + 3'(aximFb.r.last != (beat_q == LastBeat));
                    if (beat_q == LastBeat) begin
                        beat_d = '0;
                        if (burst_q == LastBurst) begin
                            burst_d = '0;
                            state_d = DONE;
                        end else begin
                            burst_d = burst_q + 32'd1;
                            state_d = RD_ADDR;
                        end
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Saturate rather than wrap so a long failing run never reads as clean.
        err_sum = {3'b000, errors_q} + {{ErrorCountWidth{1'b0}}, err_inc};
        if (err_inc != 3'd0) begin
            errors_d = (err_sum > {3'b000, {ErrorCountWidth{1'b1}}}) ? '1
                                                                    : err_sum[ErrorCountWidth-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clockAxim or negedge resetAxim) begin
        if (!resetAxim) begin
            state_q  <= IDLE;
            seed_q   <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            errors_q <= '0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            errors_q <= errors_d;
        end
    end

    assign busy   = (state_q != IDLE) && (state_q != DONE);
    assign done   = (state_q == DONE);
    assign errors = errors_q;

endmodule

// File: doc/ocsim_axim_tester.md
Name: ocsim_axim_tester

Overview:
- Simulation AXI4 master that drives write bursts, then read bursts, into one AXI slave port and checks read data against a deterministic pattern.
- Sits directly upstream of the sim AXI memory model (one instance per port); its axim/aximFb pair connects straight to one memory port.
- Used as self-checking traffic source for memory-path regressions.

Parameters:
- AximType, oclib_pkg::axi4m_256_s, master-to-slave struct (aw/ar/w, valids, rready/bready)
- AximFbType, oclib_pkg::axi4m_256_fb_s, slave-to-master struct (r/b, readys, valids)
- BaseAddress, 32'h0000_0000, byte address of first burst
- Bursts, 16, number of write bursts and number of read bursts (>=1)
- BurstLen, 4, beats per burst, 1..256
- AxiId, 0, id driven on aw/ar and required on r/b
- ErrorCountWidth, 16, width of errors output

Ports:
- clockAxim  input  1  AXI clock
- resetAxim  input  1  asynchronous, active-low reset
- axim  output  $bits(AximType)  AXI master request channels
- aximFb  input  $bits(AximFbType)  AXI slave feedback channels
- go  input  1  start pulse; sampled only in IDLE
- seed  input  32  pattern seed; captured on accepted go
- busy  output  1  high from accepted go until DONE
- done  output  1  level; high in DONE until next accepted go
- errors  output  ErrorCountWidth  saturating mismatch/response error count

Behaviour:
- Reset (resetAxim low, asynchronous): all valids (awvalid, wvalid, arvalid) 0, rready 0, bready 0, busy 0, done 0, errors 0, burst/beat counters 0, state IDLE. Payload fields 0.
- W = $bits(w.data), Bytes = W/8. Burst n address = BaseAddress + n*BurstLen*Bytes, mod 2^32. Beat k address = burst address + k*Bytes.
- Pattern: data of beat at address A = W/32 lanes; lane j = (A + 4*j) ^ seed (32-bit wrap).
- aw/ar: id=AxiId, len=BurstLen-1, size=log2(Bytes), burst=INCR, other fields 0. w: strb all ones, last on beat BurstLen-1.
- One transaction outstanding at a time. States:
  - IDLE: go=1 -> WR_ADDR; capture seed, clear errors, done<=0, busy<=1.
  - WR_ADDR: awvalid=1 held stable until awready; then WR_DATA.
  - WR_DATA: wvalid=1, one beat per cycle with wready; data/last stable while stalled; after last beat -> WR_RESP.
  - WR_RESP: bready asserted; on bvalid&&bready check resp==0 and id==AxiId (each failure +1 error); if more bursts -> WR_ADDR (next burst) else -> RD_ADDR (burst counter 0).
  - RD_ADDR: arvalid=1 held until arready; then RD_DATA.
  - RD_DATA: rready asserted; each accepted beat compares data to pattern, resp==0, id==AxiId, last==(beat==BurstLen-1); each failing check +1. After the last expected beat -> next RD_ADDR or DONE.
  - DONE: busy 0, done 1; go -> WR_ADDR (restart as in IDLE).
- Valids never drop before handshake; no payload change while valid&&!ready.
- AW accepted before W issued (memory model requires both, no deadlock since aw is held).
- errors saturates at all-ones; never wraps.
- go while busy ignored. Reset mid-transaction abandons it immediately; slave responses after reset deassertion that arrive with rready/bready low are not consumed.

Optional Feature:
- OCSIM_AXIM_TESTER_RANDOM_READY_EN: defined -> in WR_RESP/RD_DATA, rready/bready each cycle = ocsim_pkg::RandPercent(ReadyPercent), ReadyPercent an int variable default 50, overridable by hierarchical assignment; beats only consumed on handshake. Undefined -> rready/bready constant 1 in those states, 0 elsewhere.

Test Plan:
- Bursts=4, BurstLen=2, BaseAddress=0x1000, seed=0xA5A5A5A5, default memory model -> 8 write beats at 0x1000..0x10E0, 8 read beats, done=1, busy=0, errors=0.
- Same run, after write phase force memory word at 0x1020 to 0 -> errors=1, done=1.
- BurstLen=1, Bursts=3 -> every w beat has last=1, every r beat last=1, errors=0.
- go pulsed during RD_DATA -> ignored, single run completes, errors=0; go in DONE -> second run with new seed 0x1234 passes, errors=0.
- resetAxim low mid-RD_DATA -> same-cycle all valids/readys 0, busy=0, done=0, errors=0; after memory reset and new go, run passes.
- With OCSIM_AXIM_TESTER_RANDOM_READY_EN, ReadyPercent=10, Bursts=8, BurstLen=16 -> completes, errors=0, no valid deasserted before handshake (assertion).
